// File: rtl/npu_ram_wr_sched.sv
// npu_ram_wr_sched: round-robin write scheduler for the NPU line RAM.
// Rev 1.0 - registered grant/write outputs with post-write refresh gap.
`default_nettype none

module npu_ram_wr_sched #(
    parameter int NREQ     = 4,
    parameter int LINE_W   = 4,
    parameter int NLINES   = 12,
    parameter int IDLE_GAP = 1,
    localparam int SEL_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*LINE_W-1:0] line_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   err_o,
    output logic                   en_w_o,
    output logic [LINE_W-1:0]      w_line_o,
    output logic [SEL_W-1:0]       sel_o,
    output logic                   rd_valid_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [2:0] GAP_INIT = 3'(IDLE_GAP - 1);

    state_t              state, state_nxt;
    logic [2:0]          gap_cnt, gap_nxt;
    logic [SEL_W-1:0]    rr_ptr, rr_nxt;
    logic [SEL_W-1:0]    winner;
    logic                found;
    logic [LINE_W-1:0]   winner_line;
    logic                line_ok;
    int                  idx;

    logic [NREQ-1:0]     gnt_nxt;
    logic                err_nxt;
    logic                en_w_nxt;
    logic [LINE_W-1:0]   w_line_nxt;
    logic [SEL_W-1:0]    sel_nxt;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    assign winner_line = line_i[winner*LINE_W +: LINE_W];
    assign line_ok     = int'(winner_line) < NLINES;

    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap_cnt;
        rr_nxt     = rr_ptr;
        gnt_nxt    = '0;
        err_nxt    = 1'b0;
        en_w_nxt   = 1'b0;
        w_line_nxt = w_line_o;
        sel_nxt    = sel_o;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt = NREQ'(1) << winner;
                    sel_nxt = winner;
                    rr_nxt  = (winner == SEL_W'(NREQ - 1)) ? '0 : winner + SEL_W'(1);
                    if (line_ok) begin
                        state_nxt  = WRITE;
                        en_w_nxt   = 1'b1;
                        w_line_nxt = winner_line;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_nxt = GAP;
                gap_nxt   = GAP_INIT;
            end
            GAP: begin
                if (gap_cnt == 3'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = GAP;
                gap_nxt   = GAP_INIT;
            end
        endcase
    end

    // Reset parks in GAP so the RAM outputs settle before the first write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= GAP;
            gap_cnt    <= GAP_INIT;
            rr_ptr     <= '0;
            gnt_o      <= '0;
            err_o      <= 1'b0;
            en_w_o     <= 1'b0;
            w_line_o   <= '0;
            sel_o      <= '0;
            rd_valid_o <= 1'b0;
            busy_o     <= 1'b1;
        end else begin
            state      <= state_nxt;
            gap_cnt    <= gap_nxt;
            rr_ptr     <= rr_nxt;
            gnt_o      <= gnt_nxt;
            err_o      <= err_nxt;
            en_w_o     <= en_w_nxt;
            w_line_o   <= w_line_nxt;
            sel_o      <= sel_nxt;
            rd_valid_o <= (state_nxt == IDLE);
            busy_o     <= (state_nxt != IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_npu_ram_wr_sched.sv
// Scoreboard bench for npu_ram_wr_sched (IDLE_GAP=1 main instance, IDLE_GAP=3 second instance).
`timescale 1ns/1ps
`default_nettype none

module tb_npu_ram_wr_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] line;
    logic [3:0]  gnt;
    logic        err;
    logic        en_w;
    logic [3:0]  w_line;
    logic [1:0]  sel;
    logic        rd_valid;
    logic        busy;

    logic [3:0]  req3;
    logic [15:0] line3;
    logic [3:0]  gnt3;
    logic        err3;
    logic        en_w3;
    logic [3:0]  w_line3;
    logic [1:0]  sel3;
    logic        rd_valid3;
    logic        busy3;

    npu_ram_wr_sched #(.NREQ(4), .LINE_W(4), .NLINES(12), .IDLE_GAP(1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .line_i(line),
        .gnt_o(gnt), .err_o(err), .en_w_o(en_w), .w_line_o(w_line),
        .sel_o(sel), .rd_valid_o(rd_valid), .busy_o(busy)
    );

    npu_ram_wr_sched #(.NREQ(4), .LINE_W(4), .NLINES(12), .IDLE_GAP(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .line_i(line3),
        .gnt_o(gnt3), .err_o(err3), .en_w_o(en_w3), .w_line_o(w_line3),
        .sel_o(sel3), .rd_valid_o(rd_valid3), .busy_o(busy3)
    );

    typedef struct {
        logic [3:0] gnt;
        logic       err;
        logic       en_w;
        logic [3:0] w_line;
        logic [1:0] sel;
        int         gap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_gnt_cyc = 0;
    logic prev_en_w = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic er, input logic en,
                        input logic [3:0] ln, input logic [1:0] s, input int gp);
        exp_t x;
        x.gnt = g; x.err = er; x.en_w = en; x.w_line = ln; x.sel = s; x.gap = gp;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no grant within 20 cycles, gnt=%b", name, gnt);
        end
    endtask

    // Monitor: every grant pulse is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            if (en_w) check("en_w_not_back_to_back", 32'(prev_en_w), 32'd0);
            prev_en_w = en_w;
            if (gnt != 4'd0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got gnt=%b, expected no grant", gnt);
                end else begin
                    e = sb.pop_front();
                    check("sb_gnt",  32'(gnt),  32'(e.gnt));
                    check("sb_err",  32'(err),  32'(e.err));
                    check("sb_en_w", 32'(en_w), 32'(e.en_w));
                    check("sb_sel",  32'(sel),  32'(e.sel));
                    if (e.en_w) check("sb_w_line", 32'(w_line), 32'(e.w_line));
                    if (e.gap > 0) check("sb_grant_spacing", 32'(cyc - last_gnt_cyc), 32'(e.gap));
                    last_gnt_cyc = cyc;
                end
            end
        end else begin
            prev_en_w = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        bit seen;
        rst = 1'b0; req = 4'd0; line = 16'd0; req3 = 4'd0; line3 = 16'd0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_gnt",      32'(gnt),      32'd0);
        check("rst_err",      32'(err),      32'd0);
        check("rst_en_w",     32'(en_w),     32'd0);
        check("rst_w_line",   32'(w_line),   32'd0);
        check("rst_sel",      32'(sel),      32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_busy",     32'(busy),     32'd1);
        check("rst_busy3",    32'(busy3),    32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_rd_valid", 32'(rd_valid),  32'd1);
        check("post_rst_busy",     32'(busy),      32'd0);
        check("post_rst_rd_valid3_e1", 32'(rd_valid3), 32'd0);
        @(negedge clk);
        check("post_rst_rd_valid3_e2", 32'(rd_valid3), 32'd0);
        check("idle_en_w", 32'(en_w), 32'd0);
        @(negedge clk);
        check("post_rst_rd_valid3_e3", 32'(rd_valid3), 32'd1);

        // All four requesting: rotation 0,1,2,3,0 every 3 cycles.
        push(4'b0001, 1'b0, 1'b1, 4'd2, 2'd0, 0);
        push(4'b0010, 1'b0, 1'b1, 4'd5, 2'd1, 3);
        push(4'b0100, 1'b0, 1'b1, 4'd7, 2'd2, 3);
        push(4'b1000, 1'b0, 1'b1, 4'd9, 2'd3, 3);
        push(4'b0001, 1'b0, 1'b1, 4'd2, 2'd0, 3);
        req = 4'b1111; line = 16'h9752;
        for (int k = 0; k < 5; k++) wait_gnt("rr_grant");
        req = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("rr_rd_valid_after", 32'(rd_valid), 32'd1);

        // Single write from requester 0 to line 3.
        push(4'b0001, 1'b0, 1'b1, 4'd3, 2'd0, 0);
        req = 4'b0001; line = 16'h0003;
        wait_gnt("single_grant");
        req = 4'd0;
        check("single_rd_valid_wr", 32'(rd_valid), 32'd0);
        check("single_busy_wr",     32'(busy),     32'd1);
        @(negedge clk);
        check("single_en_w_gap",    32'(en_w),     32'd0);
        check("single_gnt_gap",     32'(gnt),      32'd0);
        check("single_rd_valid_gap",32'(rd_valid), 32'd0);
        check("single_w_line_hold", 32'(w_line),   32'd3);
        @(negedge clk);
        check("single_rd_valid_back", 32'(rd_valid), 32'd1);
        check("single_busy_back",     32'(busy),     32'd0);

        // Invalid line 13 from requester 2: error pulse, no write.
        push(4'b0100, 1'b1, 1'b0, 4'd0, 2'd2, 0);
        req = 4'b0100; line = 16'h0D00;
        wait_gnt("err_grant");
        req = 4'd0;
        check("err_rd_valid", 32'(rd_valid), 32'd1);
        check("err_busy",     32'(busy),     32'd0);
        @(negedge clk);
        check("err_gnt_clear", 32'(gnt),  32'd0);
        check("err_err_clear", 32'(err),  32'd0);
        check("err_en_w_low",  32'(en_w), 32'd0);
        check("err_rd_valid_hold", 32'(rd_valid), 32'd1);

        // Reset mid-WRITE: rr_ptr is 3 here, so requester 3 wins first.
        push(4'b1000, 1'b0, 1'b1, 4'd5, 2'd3, 0);
        req = 4'b1111; line = 16'h5555;
        wait_gnt("rst_mid_grant");
        #2 rst = 1'b0;
        #1;
        check("rst_mid_en_w",     32'(en_w),     32'd0);
        check("rst_mid_gnt",      32'(gnt),      32'd0);
        check("rst_mid_busy",     32'(busy),     32'd1);
        check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_mid_w_line",   32'(w_line),   32'd0);
        push(4'b0001, 1'b0, 1'b1, 4'd5, 2'd0, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_gnt("rst_ptr_grant");
        req = 4'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ptr_rd_valid", 32'(rd_valid), 32'd1);

        // IDLE_GAP=3 instance: exactly three refresh cycles after the write.
        req3 = 4'b0010; line3 = 16'h00B0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt3 != 4'd0) begin
                seen = 1'b1;
                break;
            end
        end
        req3 = 4'd0;
        check("gap3_seen",   32'(seen),    32'd1);
        check("gap3_gnt",    32'(gnt3),    32'b0010);
        check("gap3_en_w",   32'(en_w3),   32'd1);
        check("gap3_w_line", 32'(w_line3), 32'd11);
        check("gap3_sel",    32'(sel3),    32'd1);
        check("gap3_err",    32'(err3),    32'd0);
        low = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rd_valid3) break;
            if (!en_w3) low++;
        end
        check("gap3_low_cycles", 32'(low),       32'd3);
        check("gap3_rd_valid",   32'(rd_valid3), 32'd1);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
